// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, one write port, two read ports with same-cycle WB bypass
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass lets the ID stage see the value WB is writing this very cycle.
    always_comb begin
        rdata1 = '0;
        if (rst || (raddr1 == '0) || !re1) begin
            rdata1 = '0;
        end else if (we && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || (raddr2 == '0) || !re2) begin
            rdata2 = '0;
        end else if (we && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking bench for regfile: architectural model plus directed literal checks
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;
    bit done = 1'b0;

    logic [31:0] arch [32];

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) arch[i] = '0;
    end

    // Architectural state as the ISA sees it: reset zeroes everything, r0 never changes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) arch[i] = '0;
        end else if (we && waddr != 0) begin
            arch[waddr] = wdata;
        end
    end

    function automatic logic [31:0] expect_read(input logic en, input logic [4:0] a);
        if (rst) return 32'h0;
        if (a == 0) return 32'h0;
        if (!en) return 32'h0;
        if (we && a == waddr) return wdata;
        return arch[a];
    endfunction

    always @(negedge clk) begin
        if (armed && !done) begin
            logic [31:0] e1, e2;
            e1 = expect_read(re1, raddr1);
            e2 = expect_read(re2, raddr2);
            n_cmp++;
            if (rdata1 !== e1) begin
                n_bad++;
                $display("FAIL model_port1 t=%0t raddr1=%0d got=%h want=%h", $time, raddr1, rdata1, e1);
            end
            n_cmp++;
            if (rdata2 !== e2) begin
                n_bad++;
                $display("FAIL model_port2 t=%0t raddr2=%0d got=%h want=%h", $time, raddr2, rdata2, e2);
            end
        end
    end

    task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        @(posedge clk);
        #1;
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        armed = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    initial begin
        // Initial reset: reads return 0 whatever the address.
        step(1, 0, 0, 0, 1, 5'd5, 1, 5'd31);
        check("rst_read1", rdata1, 32'h0);
        check("rst_read2", rdata2, 32'h0);

        // 1. reset clear
        step(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 0, 5'd5);
        check("t1_bypass", rdata1, 32'hDEADBEEF);
        step(1, 1, 5'd6, 32'h00000001, 1, 5'd5, 1, 5'd6);
        check("t1_rst_p1", rdata1, 32'h0);
        check("t1_rst_p2", rdata2, 32'h0);
        step(0, 0, 0, 0, 1, 5'd5, 1, 5'd6);
        check("t1_after_rst_r5", rdata1, 32'h0);
        check("t1_after_rst_r6", rdata2, 32'h0);

        // 2. basic write/read, port 2 disabled
        step(0, 1, 5'd7, 32'h12345678, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd7, 0, 5'd7);
        check("t2_read_r7", rdata1, 32'h12345678);
        check("t2_re2_off", rdata2, 32'h0);

        // 3. same-cycle bypass on both ports
        step(0, 1, 5'd3, 32'h11111111, 0, 0, 0, 0);
        step(0, 1, 5'd3, 32'h22222222, 1, 5'd3, 1, 5'd3);
        check("t3_bypass_p1", rdata1, 32'h22222222);
        check("t3_bypass_p2", rdata2, 32'h22222222);
        step(0, 0, 0, 0, 1, 5'd3, 1, 5'd3);
        check("t3_stored_p1", rdata1, 32'h22222222);
        check("t3_stored_p2", rdata2, 32'h22222222);

        // 4. register zero
        step(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0);
        check("t4_r0_same", rdata1, 32'h0);
        check("t4_r0_same_p2", rdata2, 32'h0);
        step(0, 0, 0, 0, 1, 5'd0, 0, 0);
        check("t4_r0_next", rdata1, 32'h0);

        // 5. back-to-back writes to r9
        step(0, 1, 5'd9, 32'hAAAA0000, 1, 5'd9, 0, 0);
        check("t5_first_bypass", rdata1, 32'hAAAA0000);
        step(0, 1, 5'd9, 32'h0000BBBB, 1, 5'd9, 1, 5'd9);
        check("t5_second_bypass", rdata1, 32'h0000BBBB);
        step(0, 0, 0, 0, 1, 5'd9, 0, 0);
        check("t5_last_wins", rdata1, 32'h0000BBBB);

        // 6. full sweep
        for (int i = 1; i < 32; i++) begin
            step(0, 1, 5'(i), 32'(i) * 32'h01010101, 0, 0, 0, 0);
        end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i));
            check($sformatf("t6_p1_r%0d", i), rdata1, 32'(i) * 32'h01010101);
            check($sformatf("t6_p2_r%0d", 31 - i), rdata2, 32'(31 - i) * 32'h01010101);
        end
        step(0, 0, 0, 0, 1, 5'd31, 1, 5'd16);
        check("t6_r31_lit", rdata1, 32'h1F1F1F1F);
        check("t6_r16_lit", rdata2, 32'h10101010);
        step(1, 1, 5'd4, 32'h00000005, 1, 5'd4, 0, 0);
        check("t6_rst_write_read", rdata1, 32'h0);
        step(0, 0, 0, 0, 1, 5'd4, 1, 5'd31);
        check("t6_r4_lost", rdata1, 32'h0);
        check("t6_r31_cleared", rdata2, 32'h0);

        @(posedge clk);
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
